// File: rtl/fft_stream_sequencer.sv
// Frame-level controller for streaming FFT cores: launches frames, gates input beats, frames output bursts.
// Optional watchdog enabled by defining FFT_SEQ_TIMEOUT_EN.
module fft_stream_sequencer #(
  parameter int unsigned FFT_SIZE        = 16,
  parameter int unsigned STREAM_WIDTH    = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       src_valid,
  output logic       src_ready,
  output logic       fft_next,
  output logic       fft_in_en,
  input  logic       fft_next_out,
  output logic       dst_valid,
  output logic       dst_first,
  output logic       dst_last,
  output logic [3:0] outstanding,
  output logic       busy,
  output logic [2:0] err,
  input  logic       err_clr
);

  localparam int unsigned CPF    = FFT_SIZE / STREAM_WIDTH;
  localparam int unsigned CW     = (CPF > 2) ? $clog2(CPF) : 1;
  localparam logic [3:0]  MAX_OS = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_STREAM} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_in_cnt, w_in_cnt_nxt;
  logic [CW-1:0]   r_out_cnt;
  logic            r_dst_valid, r_dst_first, r_dst_last;
  logic [3:0]      r_outstanding;
  logic [2:0]      r_err;
  logic            w_inc, w_dec, w_accept, w_overlap, w_underrun, w_timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_in_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_in_cnt <= w_in_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_in_cnt_nxt = r_in_cnt;
    case (r_state)
      S_IDLE:   if (src_valid && (r_outstanding < MAX_OS)) w_state_nxt = S_ARM;
      S_ARM: begin
        w_state_nxt  = S_STREAM;
        w_in_cnt_nxt = '0;
      end
      S_STREAM: begin
        w_in_cnt_nxt = r_in_cnt + 1'b1;
        if (r_in_cnt == CW'(CPF - 1)) begin
          w_state_nxt  = S_IDLE;
          w_in_cnt_nxt = '0;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign fft_next  = (r_state == S_ARM);
  assign src_ready = (r_state == S_STREAM);
  assign fft_in_en = src_ready;

  // A new output pulse is legal only when a frame is in flight and no burst is mid-way.
  assign w_accept   = fft_next_out && (r_outstanding != 4'd0) && !(r_dst_valid && !r_dst_last);
  assign w_overlap  = fft_next_out && !w_accept;
  assign w_underrun = src_ready && !src_valid;
  assign w_inc      = (r_state == S_ARM);
  assign w_dec      = r_dst_last && (r_outstanding != 4'd0);

`ifdef FFT_SEQ_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] r_wd;

  assign w_timeout = (r_outstanding != 4'd0) && !r_dst_valid && !fft_next_out &&
                     (r_wd == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wd <= '0;
    end else if (fft_next_out || (r_outstanding == 4'd0) || w_timeout) begin
      r_wd <= '0;
    end else if (!r_dst_valid) begin
      r_wd <= r_wd + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dst_valid <= 1'b0;
      r_dst_first <= 1'b0;
      r_dst_last  <= 1'b0;
      r_out_cnt   <= '0;
    end else if (w_timeout) begin
      r_dst_valid <= 1'b0;
      r_dst_first <= 1'b0;
      r_dst_last  <= 1'b0;
      r_out_cnt   <= '0;
    end else if (w_accept) begin
      r_dst_valid <= 1'b1;
      r_dst_first <= 1'b1;
      r_dst_last  <= 1'b0;
      r_out_cnt   <= '0;
    end else if (r_dst_valid) begin
      r_dst_first <= 1'b0;
      if (r_dst_last) begin
        r_dst_valid <= 1'b0;
        r_dst_last  <= 1'b0;
      end else begin
        r_out_cnt  <= r_out_cnt + 1'b1;
        r_dst_last <= (r_out_cnt == CW'(CPF - 2));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outstanding <= '0;
    end else if (w_timeout) begin
      r_outstanding <= '0;
    end else if (w_inc && !w_dec && (r_outstanding != 4'hF)) begin
      r_outstanding <= r_outstanding + 4'd1;
    end else if (w_dec && !w_inc) begin
      r_outstanding <= r_outstanding - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= '0;
    end else if (err_clr) begin
      r_err <= {w_timeout, w_overlap, w_underrun};
    end else begin
      r_err <= r_err | {w_timeout, w_overlap, w_underrun};
    end
  end

  assign dst_valid   = r_dst_valid;
  assign dst_first   = r_dst_first;
  assign dst_last    = r_dst_last;
  assign outstanding = r_outstanding;
  assign err         = r_err;
  assign busy        = (r_state != S_IDLE) || (r_outstanding != 4'd0);

endmodule

// File: tb/tb_fft_stream_sequencer.sv
// Directed bench for fft_stream_sequencer (CPF=4, MAX_OUTSTANDING=2); output beats checked against a timed scoreboard.
module tb_fft_stream_sequencer;

  localparam int CPF = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       src_valid = 1'b0;
  logic       fft_next_out = 1'b0;
  logic       err_clr = 1'b0;
  logic       src_ready, fft_next, fft_in_en, dst_valid, dst_first, dst_last, busy;
  logic [3:0] outstanding;
  logic [2:0] err;

  typedef struct {
    int   cyc;
    logic first;
    logic last;
  } beat_t;

  beat_t sb[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base     = 0;

  always #5 clk = ~clk;

  fft_stream_sequencer #(
    .FFT_SIZE(16),
    .STREAM_WIDTH(4),
    .MAX_OUTSTANDING(2),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk),
    .reset(reset),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .fft_next(fft_next),
    .fft_in_en(fft_in_en),
    .fft_next_out(fft_next_out),
    .dst_valid(dst_valid),
    .dst_first(dst_first),
    .dst_last(dst_last),
    .outstanding(outstanding),
    .busy(busy),
    .err(err),
    .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_frame();
    for (int i = 1; i <= CPF; i++) begin
      beat_t b;
      b.cyc   = cyc + i;
      b.first = (i == 1);
      b.last  = (i == CPF);
      sb.push_back(b);
    end
  endtask

  task automatic mon();
    beat_t b;
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      b = sb.pop_front();
      chk("dst_valid", 32'(dst_valid), 32'(1));
      chk("dst_first", 32'(dst_first), 32'(b.first));
      chk("dst_last",  32'(dst_last),  32'(b.last));
    end else begin
      chk("dst_idle", 32'({dst_valid, dst_first, dst_last}), 32'(0));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mon();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'({src_ready, fft_next, fft_in_en, dst_valid, dst_first, dst_last,
                           outstanding, busy, err}), 32'(0));

    // Launch sequence with src_valid held high, cap at 2, then one output frame frees a slot
    reset = 1'b1;
    src_valid = 1'b1;
    cyc = 0;
    chk("busy_c0", 32'(busy), 32'(0));
    chk("next_c0", 32'(fft_next), 32'(0));
    for (int c = 1; c <= 27; c++) begin
      int exp_os;
      tick();
      exp_os = (cyc < 2) ? 0 : (cyc < 8) ? 1 : (cyc < 21) ? 2 : (cyc < 23) ? 1 : 2;
      chk("fft_next",  32'(fft_next),  32'(cyc == 1 || cyc == 7 || cyc == 22));
      chk("src_ready", 32'(src_ready),
          32'((cyc >= 2 && cyc <= 5) || (cyc >= 8 && cyc <= 11) || (cyc >= 23 && cyc <= 26)));
      chk("fft_in_en", 32'(fft_in_en), 32'(src_ready));
      chk("outstanding", 32'(outstanding), 32'(exp_os));
      if (cyc == 16) begin
        fft_next_out = 1'b1;
        push_frame();
      end else begin
        fft_next_out = 1'b0;
      end
      if (cyc == 27) src_valid = 1'b0;
    end
    chk("err_after_launch", 32'(err), 32'(0));

    // Back-to-back output frames
    while (cyc < 30) tick();
    fft_next_out = 1'b1;
    push_frame();
    tick();
    fft_next_out = 1'b0;
    while (cyc < 34) tick();
    chk("os_b2b_34", 32'(outstanding), 32'(2));
    fft_next_out = 1'b1;
    push_frame();
    tick();
    fft_next_out = 1'b0;
    chk("os_b2b_35", 32'(outstanding), 32'(1));
    while (cyc < 40) tick();
    chk("os_b2b_end", 32'(outstanding), 32'(0));
    chk("busy_b2b_end", 32'(busy), 32'(0));
    chk("err_b2b", 32'(err), 32'(0));

    // Pulse with nothing in flight, then err_clr alongside a new launch
    fft_next_out = 1'b1;
    tick();
    fft_next_out = 1'b0;
    chk("err_noframe", 32'(err), 32'(3'b010));
    err_clr = 1'b1;
    src_valid = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", 32'(err), 32'(0));
    chk("fft_next_42", 32'(fft_next), 32'(1));
    while (cyc < 47) tick();
    src_valid = 1'b0;
    chk("os_47", 32'(outstanding), 32'(1));

    // Overlapping pulse mid-burst is flagged and ignored
    while (cyc < 50) tick();
    fft_next_out = 1'b1;
    push_frame();
    tick();
    fft_next_out = 1'b0;
    tick();
    fft_next_out = 1'b1;
    tick();
    fft_next_out = 1'b0;
    chk("err_overlap", 32'(err), 32'(3'b010));
    while (cyc < 55) tick();
    chk("os_55", 32'(outstanding), 32'(0));
    err_clr = 1'b1;
    fft_next_out = 1'b1;
    tick();
    fft_next_out = 1'b0;
    chk("err_set_wins", 32'(err), 32'(3'b010));
    tick();
    err_clr = 1'b0;
    chk("err_clr_57", 32'(err), 32'(0));

    // Underrun on second STREAM beat
    src_valid = 1'b1;
    tick();
    chk("fft_next_58", 32'(fft_next), 32'(1));
    tick();
    chk("ur_ready_59", 32'(src_ready), 32'(1));
    tick();
    src_valid = 1'b0;
    chk("ur_ready_60", 32'(src_ready), 32'(1));
    tick();
    src_valid = 1'b1;
    chk("ur_ready_61", 32'(src_ready), 32'(1));
    chk("err_underrun", 32'(err), 32'(3'b001));
    tick();
    chk("ur_ready_62", 32'(src_ready), 32'(1));
    tick();
    src_valid = 1'b0;
    chk("ur_ready_63", 32'(src_ready), 32'(0));
    chk("os_63", 32'(outstanding), 32'(1));
    tick();
    chk("ur_next_64", 32'(fft_next), 32'(0));

    // Reset while streaming and outputting
    src_valid = 1'b1;
    tick();
    chk("fft_next_65", 32'(fft_next), 32'(1));
    fft_next_out = 1'b1;
    push_frame();
    tick();
    fft_next_out = 1'b0;
    tick();
    chk("rst_pre_ready", 32'(src_ready), 32'(1));
    #1 reset = 1'b0;
    #1;
    chk("rst_async", 32'({src_ready, fft_next, fft_in_en, dst_valid, dst_first, dst_last,
                          outstanding, busy, err}), 32'(0));
    sb.delete();
    src_valid = 1'b0;
    tick();
    tick();
    chk("rst_hold_os", 32'(outstanding), 32'(0));

    // One frame in flight with no output pulse for the watchdog interval
    reset = 1'b1;
    src_valid = 1'b1;
    base = cyc;
    while (cyc < base + 6) tick();
    src_valid = 1'b0;
    chk("wd_os_start", 32'(outstanding), 32'(1));
    while (cyc < base + 2 + 1023) tick();
    chk("wd_before_err", 32'(err), 32'(0));
    chk("wd_before_os", 32'(outstanding), 32'(1));
    tick();
`ifdef FFT_SEQ_TIMEOUT_EN
    chk("wd_err", 32'(err), 32'(3'b100));
    chk("wd_os", 32'(outstanding), 32'(0));
    chk("wd_busy", 32'(busy), 32'(0));
`else
    chk("wd_err", 32'(err), 32'(0));
    chk("wd_os", 32'(outstanding), 32'(1));
`endif

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
